// File: rtl/bf16_pkg.sv
// Shared bfloat16 format constants, field layout and small helpers used by the
// multiplier datapath and its operand classifier.
package bf16_pkg;

    localparam int BF16_WIDTH  = 16;
    localparam int BF16_EXP_W  = 8;
    localparam int BF16_FRAC_W = 7;
    localparam int BF16_SIG_W  = BF16_FRAC_W + 1;   // significand incl. hidden bit
    localparam int BF16_PROD_W = 2 * BF16_SIG_W;    // raw significand product
    localparam int BF16_EXPI_W = 10;                // signed exponent intermediate

    localparam int              BF16_BIAS    = 127;
    localparam logic [7:0]      BF16_EXP_MAX = 8'hFF;
    localparam logic [15:0]     BF16_QNAN    = 16'h7FC0;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] frac;
    } bf16_t;

    // Signed infinity with the given sign.
    function automatic logic [15:0] bf16_inf(input logic sign);
        return {sign, BF16_EXP_MAX, 7'b0};
    endfunction

    // Signed zero with the given sign.
    function automatic logic [15:0] bf16_zero(input logic sign);
        return {sign, 15'b0};
    endfunction

endpackage

// File: rtl/bf16_classify.sv
// Decodes one bfloat16 operand into special-value flags and the significand
// with its hidden bit restored. Subnormals are reported as zero.
module bf16_classify
    import bf16_pkg::*;
(
    input  logic [15:0] x,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan,
    output logic [7:0]  sig
);

    bf16_t f;

    assign f       = x;
    assign is_zero = (f.exp == 8'h00);
    assign is_inf  = (f.exp == BF16_EXP_MAX) && (f.frac == 7'b0);
    assign is_nan  = (f.exp == BF16_EXP_MAX) && (f.frac != 7'b0);
    // Hidden bit is only present for normal numbers; zero/subnormal are
    // overridden by the special-case path downstream anyway.
    assign sig     = {~is_zero, f.frac};

endmodule

// File: rtl/bfloat16_mult.sv
// Two-stage bfloat16 multiplier. Stage 1 forms sign, biased exponent sum,
// significand product and operand classes; stage 2 normalises, rounds to
// nearest-even, resolves special cases and registers the result.
module bfloat16_mult
    import bf16_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    output logic [15:0] result
);

    // ------------------------------------------------------------------
    // Operand classification, one classifier per operand
    // ------------------------------------------------------------------
    logic [15:0] op      [2];
    logic [1:0]  op_zero;
    logic [1:0]  op_inf;
    logic [1:0]  op_nan;
    logic [7:0]  op_sig  [2];

    assign op[0] = a;
    assign op[1] = b;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_classify
            bf16_classify u_classify (
                .x       (op[gi]),
                .is_zero (op_zero[gi]),
                .is_inf  (op_inf[gi]),
                .is_nan  (op_nan[gi]),
                .sig     (op_sig[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 1 combinational terms
    // ------------------------------------------------------------------
    logic                          s1_sign_next;
    logic signed [BF16_EXPI_W-1:0] s1_exp_next;
    logic [BF16_PROD_W-1:0]        s1_prod_next;
    logic                          s1_nan_next;
    logic                          s1_infzero_next;
    logic                          s1_inf_next;
    logic                          s1_zero_next;

    assign s1_sign_next    = a[15] ^ b[15];
    assign s1_exp_next     = $signed({2'b00, a[14:7]}) + $signed({2'b00, b[14:7]})
                           - $signed(10'(BF16_BIAS));
    assign s1_prod_next    = {8'b0, op_sig[0]} * {8'b0, op_sig[1]};
    assign s1_nan_next     = |op_nan;
    assign s1_infzero_next = (op_inf[0] & op_zero[1]) | (op_zero[0] & op_inf[1]);
    assign s1_inf_next     = |op_inf;
    assign s1_zero_next    = |op_zero;

    logic                          s1_valid_reg;
    logic                          s1_sign_reg;
    logic signed [BF16_EXPI_W-1:0] s1_exp_reg;
    logic [BF16_PROD_W-1:0]        s1_prod_reg;
    logic                          s1_nan_reg;
    logic                          s1_infzero_reg;
    logic                          s1_inf_reg;
    logic                          s1_zero_reg;

    // Stage 1 valid bit; cleared by reset so in-flight pairs are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= in_valid;
        end
    end

    // Stage 1 datapath registers; qualified by s1_valid_reg downstream.
    always_ff @(posedge clk) begin
        s1_sign_reg    <= s1_sign_next;
        s1_exp_reg     <= s1_exp_next;
        s1_prod_reg    <= s1_prod_next;
        s1_nan_reg     <= s1_nan_next;
        s1_infzero_reg <= s1_infzero_next;
        s1_inf_reg     <= s1_inf_next;
        s1_zero_reg    <= s1_zero_next;
    end

    // ------------------------------------------------------------------
    // Stage 2: normalise, round, special cases
    // ------------------------------------------------------------------
    logic signed [BF16_EXPI_W-1:0] exp_norm;
    logic signed [BF16_EXPI_W-1:0] exp_rnd;
    logic [6:0]                    frac_trunc;
    logic                          guard_bit;
    logic                          sticky_bit;
    logic                          round_up;
    logic [7:0]                    frac_rnd;
    logic [15:0]                   result_next;

    // Normalise the 1x.xx / 01.xx product, round to nearest-even and pick
    // the final encoding with NaN > Inf*0 > Inf > zero > over/underflow.
    always_comb begin
        exp_norm    = s1_exp_reg;
        frac_trunc  = s1_prod_reg[13:7];
        guard_bit   = s1_prod_reg[6];
        sticky_bit  = |s1_prod_reg[5:0];
        if (s1_prod_reg[15]) begin
            exp_norm   = s1_exp_reg + 10'sd1;
            frac_trunc = s1_prod_reg[14:8];
            guard_bit  = s1_prod_reg[7];
            sticky_bit = |s1_prod_reg[6:0];
        end

        round_up = guard_bit & (sticky_bit | frac_trunc[0]);
        frac_rnd = {1'b0, frac_trunc} + {7'b0, round_up};
        // A carry out of the fraction leaves frac_rnd[6:0] at zero, which is
        // exactly the renormalised fraction for the bumped exponent.
        exp_rnd  = exp_norm + $signed({9'b0, frac_rnd[7]});

        if (s1_nan_reg || s1_infzero_reg) begin
            result_next = BF16_QNAN;
        end else if (s1_inf_reg) begin
            result_next = bf16_inf(s1_sign_reg);
        end else if (s1_zero_reg) begin
            result_next = bf16_zero(s1_sign_reg);
        end else if (exp_rnd >= 10'sd255) begin
            result_next = bf16_inf(s1_sign_reg);
        end else if (exp_rnd <= 10'sd0) begin
            result_next = bf16_zero(s1_sign_reg);
        end else begin
            result_next = {s1_sign_reg, exp_rnd[7:0], frac_rnd[6:0]};
        end
    end

    logic        out_valid_reg;
    logic [15:0] result_reg;

    // Output stage; result only changes when a valid product arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            result_reg    <= 16'h0000;
        end else begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                result_reg <= result_next;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign result    = result_reg;

endmodule

// File: tb/tb_bfloat16_mult.sv
// Table-driven bench for bfloat16_mult with an in-order scoreboard that also
// checks the two-cycle latency, the hold behaviour and reset flushing.
module tb_bfloat16_mult;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic [15:0] result;

    bfloat16_mult dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
    } vec_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        int          due;
        int          id;
    } sb_t;

    localparam int NV = 24;

    vec_t        vecs [NV];
    sb_t         q [$];
    int          cyc;
    logic        rst_q;
    logic        mon_en;
    logic [15:0] hold_exp;
    int          checks;
    int          errors;
    int          next_id;

    // Cycle counter and sampled reset, used to model the synchronous reset.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    // Scoreboard monitor: every cycle, out_valid must match the queue's due
    // slot; valid results are popped in order, idle cycles must hold.
    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_v;
            if (rst_q) hold_exp = 16'h0000;
            exp_v = (q.size() > 0) && (q[0].due == cyc);
            checks++;
            if (out_valid !== exp_v) begin
                errors++;
                $display("FAIL out_valid cyc %0d got %b want %b", cyc, out_valid, exp_v);
            end
            if (exp_v) begin
                sb_t e;
                e = q.pop_front();
                checks++;
                if (result !== e.res) begin
                    errors++;
                    $display("FAIL result txn %0d a=%h b=%h got %h want %h",
                             e.id, e.a, e.b, result, e.res);
                end else begin
                    $display("txn %0d a=%h b=%h result=%h ok", e.id, e.a, e.b, result);
                end
                hold_exp = e.res;
            end else begin
                checks++;
                if (result !== hold_exp) begin
                    errors++;
                    $display("FAIL hold cyc %0d got %h want %h", cyc, result, hold_exp);
                end
            end
        end
    end

    // Present a pair for one cycle and record its expected product.
    task automatic drive(input logic [15:0] va, input logic [15:0] vb,
                         input logic [15:0] vr);
        sb_t e;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        e.a   = va;
        e.b   = vb;
        e.res = vr;
        e.due = cyc + 2;
        e.id  = next_id;
        next_id++;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            a        = 16'h0000;
            b        = 16'h0000;
        end
    endtask

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{16'h4000, 16'h4080, 16'h4100};  // 2 * 4 = 8
        vecs[1]  = '{16'h4060, 16'h40F8, 16'h41D9};  // 3.5 * 7.75
        vecs[2]  = '{16'h3F00, 16'h42FA, 16'h427A};  // 0.5 * 125
        vecs[3]  = '{16'hC2C8, 16'h42A0, 16'hC5FA};  // -100 * 80
        vecs[4]  = '{16'hC1A0, 16'hC2FA, 16'h451C};  // round down, sticky set
        vecs[5]  = '{16'h7F80, 16'h0000, 16'h7FC0};  // inf * 0
        vecs[6]  = '{16'hFF80, 16'h4000, 16'hFF80};  // -inf * 2
        vecs[7]  = '{16'h7F00, 16'h7F00, 16'h7F80};  // overflow
        vecs[8]  = '{16'h0080, 16'h0080, 16'h0000};  // underflow
        vecs[9]  = '{16'h8000, 16'h4000, 16'h8000};  // -0 * 2
        vecs[10] = '{16'h3F80, 16'h3F80, 16'h3F80};  // 1 * 1
        vecs[11] = '{16'h7FC1, 16'h3F80, 16'h7FC0};  // NaN in
        vecs[12] = '{16'h0000, 16'h7FC1, 16'h7FC0};  // NaN beats zero
        vecs[13] = '{16'h7F80, 16'hFF80, 16'hFF80};  // inf * -inf
        vecs[14] = '{16'h0001, 16'h4000, 16'h0000};  // subnormal as zero
        vecs[15] = '{16'h0001, 16'h7F80, 16'h7FC0};  // subnormal * inf
        vecs[16] = '{16'h3FC0, 16'h3F81, 16'h3FC2};  // tie, odd -> up
        vecs[17] = '{16'h3FC0, 16'h3F83, 16'h3FC4};  // tie, even -> stay
        vecs[18] = '{16'h3FFE, 16'h3F81, 16'h4000};  // rounding carry
        vecs[19] = '{16'h7F7E, 16'h3F81, 16'h7F80};  // overflow via rounding
        vecs[20] = '{16'h0080, 16'h3F80, 16'h0080};  // smallest normal kept
        vecs[21] = '{16'h0080, 16'h3F00, 16'h0000};  // exponent hits 0
        vecs[22] = '{16'h8000, 16'hFF80, 16'h7FC0};  // -0 * -inf
        vecs[23] = '{16'hC000, 16'hC040, 16'h40C0};  // -2 * -3 = 6

        checks   = 0;
        errors   = 0;
        next_id  = 0;
        cyc      = 0;
        rst_q    = 1'b0;
        mon_en   = 1'b0;
        hold_exp = 16'h0000;
        reset    = 1'b1;
        in_valid = 1'b0;
        a        = 16'h0000;
        b        = 16'h0000;

        @(posedge clk);
        #1;
        mon_en = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(2);

        // Whole table back to back, one pair per cycle.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].res);
        end
        idle(4);

        // Isolated pairs separated by bubbles.
        drive(16'h4000, 16'h4080, 16'h4100);
        idle(1);
        drive(16'hC2C8, 16'h42A0, 16'hC5FA);
        idle(3);

        // Reset with two pairs in flight: neither may ever appear.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a        = 16'h4060;
        b        = 16'h40F8;
        @(posedge clk);
        #1;
        a        = 16'h3F00;
        b        = 16'h42FA;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        a        = 16'h0000;
        b        = 16'h0000;
        idle(5);

        // First pair after reset release.
        drive(16'hC1A0, 16'hC2FA, 16'h451C);
        idle(5);

        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", q.size());
        end
        checks++;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bfloat16_mult.md
BFLOAT16_MULT -- requirements
Module: bfloat16_mult

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by the bfloat16 format (1 sign, 8 exponent, 7 fraction bits, bias 127).
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  a/b hold a valid operand pair this cycle.
REQ-006 a  input  16  bfloat16 multiplicand.
REQ-007 b  input  16  bfloat16 multiplier.
REQ-008 out_valid  output  1  result holds the product of the pair accepted 2 cycles earlier.
REQ-009 result  output  16  bfloat16 product a*b.

Function
REQ-010 The block SHALL be a 2-stage pipeline accepting one pair every cycle, with no backpressure and no stall input.
REQ-011 out_valid SHALL equal in_valid delayed by exactly 2 clk cycles.
REQ-012 result SHALL update only with out_valid and hold its last value while out_valid=0.
REQ-013 Stage 1 SHALL:
- compute sign = a[15] XOR b[15];
- compute a biased exponent sum ea+eb-127 in a 10-bit signed intermediate;
- form the 8x8 product of the significands with hidden 1s into a 16-bit product;
- classify both operands.
REQ-014 Stage 2 SHALL normalize: if product[15]=1, the exponent is incremented and the product shifted so the leading 1 is implicit.
REQ-015 Rounding SHALL be round-to-nearest-even on the 7-bit fraction, using guard and sticky (OR of all lower bits).
- A rounding carry out of the fraction SHALL increment the exponent.
REQ-016 Any operand with exponent 0 (zero or subnormal) SHALL be treated as zero.
- Zero times finite SHALL give signed zero {sign,15'b0}.
REQ-017 NaN input (exp=0xFF, frac!=0), or Inf times zero, SHALL give the canonical quiet NaN 0x7FC0.
REQ-018 Inf times nonzero finite, or Inf times Inf, SHALL give signed infinity {sign,8'hFF,7'b0}.
REQ-019 A final biased exponent >= 255 after rounding SHALL give signed infinity (overflow).
REQ-020 A final biased exponent <= 0 SHALL give signed zero (flush-to-zero underflow; no subnormal outputs).
REQ-021 Special-case priority SHALL be: NaN > Inf*0 > Inf > zero > overflow/underflow > normal.
REQ-022 Back-to-back pairs SHALL produce back-to-back results in order with no interaction between pipeline slots.

Reset
REQ-023 While reset=1 at a clk edge, all pipeline valid bits and out_valid SHALL clear to 0, and result SHALL clear to 0x0000.
REQ-024 Pairs in flight when reset asserts SHALL be discarded; out_valid SHALL stay 0 until 2 cycles after the first in_valid following reset release.

Structure
REQ-025 A shared package bf16_pkg SHALL hold:
- BF16_BIAS=127;
- BF16_EXP_MAX=8'hFF;
- BF16_QNAN=16'h7FC0;
- field width constants;
- a typedef struct for {sign, exp[7:0], frac[6:0]}.
REQ-026 One sub-module bf16_classify SHALL decode an operand into is_zero, is_inf, is_nan and a significand with the hidden bit; it SHALL be instantiated once per operand.

Verification
REQ-027 Integer product: a=0x4000 (2.0), b=0x4080 (4.0) -> result=0x4100 (8.0), out_valid 2 cycles after in_valid.
REQ-028 Exact fractional product: 0x4060 (3.5) * 0x40F8 (7.75) -> 0x41D9 (27.125); 0x3F00 (0.5) * 0x42FA (125) -> 0x427A (62.5).
REQ-029 Sign handling:
- 0xC2C8 (-100) * 0x42A0 (80) -> 0xC5FA (-8000);
- 0xC1A0 (-20) * 0xC2FA (-125) -> 0x451C (2500), which exercises round-down with a nonzero sticky bit.
REQ-030 Specials:
- 0x7F80 * 0x0000 -> 0x7FC0;
- 0xFF80 * 0x4000 -> 0xFF80;
- 0x7F00 * 0x7F00 -> 0x7F80 (overflow);
- 0x0080 * 0x0080 -> 0x0000 (underflow);
- 0x8000 * 0x4000 -> 0x8000.
REQ-031 Pipeline/reset:
- drive pairs on 5 consecutive cycles -> 5 consecutive in-order results;
- assert reset with 2 pairs in flight -> out_valid=0 and result=0x0000 on the next edge, and neither in-flight result ever appears.
